seg_scan_display: RTL and testbench

- Parametrised multiplexed seven-segment scanner for the processor's 32-bit `result` output. It is the generalised successor of the fixed seg0/seg1/anode display path.
- Captures a result word on a valid strobe and scans NUM_DIGITS hex digits, one per refresh tick.
- Adds three behaviours: tear-free frame-boundary update, leading-zero blanking, and a per-digit decimal-point mask.
- Sits between the processor core (`result`) and the board display pins.

---
 rtl/seg_scan_display.sv | 167 ++++++++++++++++
 tb/tb_seg_scan_display.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner: captures a hex word, swaps the shown copy only at
// frame wrap, blanks leading zeros and drives registered, polarity-adjusted display pins.
module seg_scan_display #(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_DIV    = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int PW = $clog2(REFRESH_DIV)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   data_in,
  input  logic                      data_valid,
  input  logic                      hold,
  input  logic                      blank_lz_en,
  input  logic [NUM_DIGITS-1:0]     dp_mask,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     anode,
  output logic [IW-1:0]             digit_idx,
  output logic                      frame_done,
  output logic [4*NUM_DIGITS-1:0]   captured
);

  localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [PW-1:0]           prescaler_q, prescaler_d;
  logic [IW-1:0]           digit_idx_q, digit_idx_d;
  logic [4*NUM_DIGITS-1:0] captured_q, captured_d;
  logic [4*NUM_DIGITS-1:0] display_q, display_d;
  logic                    frame_done_q, frame_done_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;

  logic                    tick_s;
  logic                    wrap_s;
  logic [3:0]              nib_s;
  logic                    dp_sel_s;
  logic                    zero_run_s;
  logic                    zero_sel_s;
  logic                    blank_s;
  logic [NUM_DIGITS-1:0]   an_hot_s;

  // Standard {g,f,e,d,c,b,a} pattern with 1 meaning lit
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0:    r = 7'b0111111;
      4'h1:    r = 7'b0000110;
      4'h2:    r = 7'b1011011;
      4'h3:    r = 7'b1001111;
      4'h4:    r = 7'b1100110;
      4'h5:    r = 7'b1101101;
      4'h6:    r = 7'b1111101;
      4'h7:    r = 7'b0000111;
      4'h8:    r = 7'b1111111;
      4'h9:    r = 7'b1101111;
      4'hA:    r = 7'b1110111;
      4'hB:    r = 7'b1111100;
      4'hC:    r = 7'b0111001;
      4'hD:    r = 7'b1011110;
      4'hE:    r = 7'b1111001;
      4'hF:    r = 7'b1110001;
      default: r = 7'b0000000;
    endcase
    return r;
  endfunction

  // Scan timing, capture and frame-boundary swap of the displayed word
  always_comb begin
    tick_s       = (prescaler_q == PW'(REFRESH_DIV - 1));
    wrap_s       = tick_s && (digit_idx_q == IW'(NUM_DIGITS - 1));
    prescaler_d  = prescaler_q + PW'(1);
    digit_idx_d  = digit_idx_q;
    captured_d   = captured_q;
    display_d    = display_q;
    frame_done_d = wrap_s;
    if (tick_s) begin
      prescaler_d = {PW{1'b0}};
      if (wrap_s) begin
        digit_idx_d = {IW{1'b0}};
        display_d   = captured_q;
      end else begin
        digit_idx_d = digit_idx_q + IW'(1);
      end
    end else begin
      prescaler_d = prescaler_q + PW'(1);
    end
    if (data_valid && !hold) begin
      captured_d = data_in;
    end else begin
      captured_d = captured_q;
    end
  end

  // Select the active nibble; zero_run_s tracks "all nibbles from the top down to i are zero"
  always_comb begin
    nib_s      = 4'h0;
    dp_sel_s   = 1'b0;
    zero_run_s = 1'b1;
    zero_sel_s = 1'b0;
    an_hot_s   = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run_s = zero_run_s && (display_q[4*i +: 4] == 4'h0);
      if (IW'(i) == digit_idx_q) begin
        nib_s       = display_q[4*i +: 4];
        dp_sel_s    = dp_mask[i];
        zero_sel_s  = zero_run_s;
        an_hot_s[i] = 1'b1;
      end else begin
        an_hot_s[i] = 1'b0;
      end
    end
    blank_s = blank_lz_en && (digit_idx_q != {IW{1'b0}}) && !dp_sel_s && zero_sel_s;
  end

  // Next values of the registered display pins
  always_comb begin
    seg_d   = SEG_OFF;
    dp_d    = DP_OFF;
    anode_d = AN_OFF;
    if (blank_s) begin
      seg_d   = SEG_OFF;
      dp_d    = DP_OFF;
      anode_d = AN_OFF;
    end else begin
      seg_d   = SEG_ACTIVE_LOW ? ~hex7(nib_s) : hex7(nib_s);
      dp_d    = dp_sel_s ? ~DP_OFF : DP_OFF;
      anode_d = AN_ACTIVE_LOW ? ~an_hot_s : an_hot_s;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      prescaler_q  <= {PW{1'b0}};
      digit_idx_q  <= {IW{1'b0}};
      captured_q   <= {(4*NUM_DIGITS){1'b0}};
      display_q    <= {(4*NUM_DIGITS){1'b0}};
      frame_done_q <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      anode_q      <= AN_OFF;
    end else begin
      prescaler_q  <= prescaler_d;
      digit_idx_q  <= digit_idx_d;
      captured_q   <= captured_d;
      display_q    <= display_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      anode_q      <= anode_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign anode      = anode_q;
  assign digit_idx  = digit_idx_q;
  assign frame_done = frame_done_q;
  assign captured   = captured_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display (4 digits, 4-cycle slots, active-low pins) with a
// time-based reference model compared every cycle plus hand-computed spot values.
module tb_seg_scan_display;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int FRAME = N * DIV;

  logic        clk;
  logic        reset;
  logic [15:0] data_in;
  logic        data_valid;
  logic        hold;
  logic        blank_lz_en;
  logic [3:0]  dp_mask;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  anode;
  logic [1:0]  digit_idx;
  logic        frame_done;
  logic [15:0] captured;

  int n_chk  = 0;
  int n_pass = 0;

  seg_scan_display #(
    .NUM_DIGITS(N), .REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid), .hold(hold),
    .blank_lz_en(blank_lz_en), .dp_mask(dp_mask), .seg(seg), .dp(dp), .anode(anode),
    .digit_idx(digit_idx), .frame_done(frame_done), .captured(captured)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [6:0] hex_lit(input int v);
    case (v)
      0: return 7'b0111111;   1: return 7'b0000110;   2: return 7'b1011011;   3: return 7'b1001111;
      4: return 7'b1100110;   5: return 7'b1101101;   6: return 7'b1111101;   7: return 7'b0000111;
      8: return 7'b1111111;   9: return 7'b1101111;  10: return 7'b1110111;  11: return 7'b1111100;
      12: return 7'b0111001; 13: return 7'b1011110;  14: return 7'b1111001;  15: return 7'b1110001;
      default: return 7'b0000000;
    endcase
  endfunction

  // Pins {seg,dp,anode} for digit d of word disp; blanked when everything from d upward is zero
  function automatic logic [11:0] exp_pins(input int d, input logic [15:0] disp,
                                           input logic [3:0] mask, input logic blen);
    logic       blank;
    logic [6:0] lit;
    logic [3:0] an;
    blank = blen && (d != 0) && !mask[d] && ((disp >> (4 * d)) == 16'h0000);
    lit   = hex_lit(int'((disp >> (4 * d)) & 16'h000F));
    an    = 4'hF;
    an[d] = 1'b0;
    if (blank) return {7'h7F, 1'b1, 4'hF};
    return {~lit, ~mask[d], an};
  endfunction

  // Reference model: m_t counts non-reset edges since the last reset edge
  bit          m_valid = 1'b0;
  int          m_t     = 0;
  logic [15:0] m_cap, m_disp;
  logic        m_fd;
  logic [11:0] m_pins;

  always @(posedge clk) begin
    if (!reset) begin
      m_valid <= 1'b1;
      m_t     <= 0;
      m_cap   <= 16'h0000;
      m_disp  <= 16'h0000;
      m_fd    <= 1'b0;
      m_pins  <= {7'h7F, 1'b1, 4'hF};
    end else if (m_valid) begin
      m_t    <= m_t + 1;
      m_pins <= exp_pins((m_t / DIV) % N, m_disp, dp_mask, blank_lz_en);
      if (data_valid && !hold) m_cap <= data_in;
      if (m_t % FRAME == FRAME - 1) begin
        m_disp <= m_cap;
        m_fd   <= 1'b1;
      end else begin
        m_fd   <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      check("seg",        32'(seg),        32'(m_pins[11:5]));
      check("dp",         32'(dp),         32'(m_pins[4]));
      check("anode",      32'(anode),      32'(m_pins[3:0]));
      check("digit_idx",  32'(digit_idx),  32'((m_t / DIV) % N));
      check("frame_done", 32'(frame_done), 32'(m_fd));
      check("captured",   32'(captured),   32'(m_cap));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pins(input string name, input logic [3:0] an, input logic [6:0] sg);
    check({name, ".anode"}, 32'(anode), 32'(an));
    check({name, ".seg"},   32'(seg),   32'(sg));
  endtask

  initial begin
    reset = 1'b0; data_in = 16'h0000; data_valid = 1'b0; hold = 1'b0;
    blank_lz_en = 1'b0; dp_mask = 4'h0;

    step(3);
    check("rst.seg", 32'(seg), 32'h7F);
    check("rst.dp", 32'(dp), 32'h1);
    check("rst.anode", 32'(anode), 32'hF);
    check("rst.digit_idx", 32'(digit_idx), 32'h0);
    check("rst.frame_done", 32'(frame_done), 32'h0);
    check("rst.captured", 32'(captured), 32'h0);

    // Basic scan of 12AF
    reset = 1'b1; data_in = 16'h12AF; data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    check("cap.12AF", 32'(captured), 32'h12AF);
    step(15);
    check("wrap1.frame_done", 32'(frame_done), 32'h1);
    step(1);
    check("wrap1.fd_low", 32'(frame_done), 32'h0);
    pins("scan.F", 4'b1110, 7'b0001110);
    step(4);
    pins("scan.A", 4'b1101, 7'b0001000);
    step(4);
    pins("scan.2", 4'b1011, 7'b0100100);
    step(4);
    pins("scan.1", 4'b0111, 7'b1111001);
    step(3);
    check("wrap2.frame_done", 32'(frame_done), 32'h1);

    // Mid-frame capture must not tear the frame in progress
    step(5);
    data_in = 16'h0005; data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    check("cap.0005", 32'(captured), 32'h0005);
    step(7);
    pins("tear.old1", 4'b0111, 7'b1111001);
    step(4);
    pins("tear.new5", 4'b1110, 7'b0010010);

    // Capture exactly on the wrap edge shows one frame later
    step(14);
    data_in = 16'h0030; data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    check("wrapcap.captured", 32'(captured), 32'h0030);
    check("wrapcap.frame_done", 32'(frame_done), 32'h1);
    step(1);
    pins("wrapcap.still5", 4'b1110, 7'b0010010);
    step(20);
    pins("wrapcap.shows3", 4'b1101, 7'b0110000);

    // Leading-zero blanking
    blank_lz_en = 1'b1; data_in = 16'h0005; data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    step(11);
    pins("lz.digit0", 4'b1110, 7'b0010010);
    step(4);
    pins("lz.digit1", 4'b1111, 7'h7F);
    check("lz.digit1.dp", 32'(dp), 32'h1);
    data_in = 16'h0000; data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    step(11);
    pins("lz.zero", 4'b1110, 7'b1000000);
    step(4);
    pins("lz.zero.d1", 4'b1111, 7'h7F);
    dp_mask = 4'b0100;
    step(4);
    pins("lz.dp2", 4'b1011, 7'b1000000);
    check("lz.dp2.dp", 32'(dp), 32'h0);
    dp_mask = 4'h0;

    // Hold blocks capture
    hold = 1'b1; data_in = 16'hBEEF; data_valid = 1'b1;
    step(1);
    check("hold.captured", 32'(captured), 32'h0000);
    hold = 1'b0;
    step(1);
    data_valid = 1'b0;
    check("release.captured", 32'(captured), 32'hBEEF);

    // Reset in the middle of digit 2
    check("pre_rst.digit_idx", 32'(digit_idx), 32'h2);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    check("midrst.digit_idx", 32'(digit_idx), 32'h0);
    check("midrst.captured", 32'(captured), 32'h0);
    check("midrst.frame_done", 32'(frame_done), 32'h0);
    pins("midrst", 4'hF, 7'h7F);
    step(3);
    check("post_rst.no_tick", 32'(digit_idx), 32'h0);
    step(1);
    check("post_rst.first_tick", 32'(digit_idx), 32'h1);
    step(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
